vga_frame_monitor: RTL and testbench
====================================

// Module: vga_frame_monitor
// PURPOSE
//  Receive side of the VGA link: samples hSync/vSync/RGB as driven off-chip by the game top.
//  Recovers pixel/line counters and locks onto 800x525 timing.
//  Per frame it publishes a 16-bit checksum and visible-pixel count, captures one probe pixel,
//  and flags line/frame timing errors. Used in benches and as an on-chip self-check tap.
// PARAMETERS
//  CLKS_PER_PIXEL  4    clk cycles per pixel (100 MHz clk, 25 MHz pixel)
//  H_TOTAL         800  pixels per line
//  V_TOTAL         525  lines per frame
//  H_VIS_START     144  first visible hc;  H_VIS_END 783 last visible hc
//  V_VIS_START     35   first visible vc;  V_VIS_END 514 last visible vc
// PORTS
//  clk          in   1   system clock; single clock domain
//  reset        in   1   synchronous, active-high
//  hSync        in   1   horizontal sync, active low
//  vSync        in   1   vertical sync, active low
//  rgb_in       in   12  {R,G,B} 4b each, as driven to vgaR/vgaG/vgaB
//  probe_x      in   10  hc of pixel to capture (absolute counter value)
//  probe_y      in   10  vc of pixel to capture
//  locked       out  1   timing lock achieved
//  h_count      out  10  recovered hc
//  v_count      out  10  recovered vc
//  frame_done   out  1   1-cycle pulse: frame_sum/pix_count updated
//  frame_sum    out  16  checksum of last good frame
//  pix_count    out  19  visible pixels sampled in last good frame
//  probe_rgb    out  12  rgb_in captured at (probe_x,probe_y)
//  line_err     out  1   1-cycle pulse: bad line length
//  frame_err    out  1   1-cycle pulse: bad line or pixel count per frame
//  err_count    out  8   saturating count of line_err, cleared only by reset
//  blank_err    out  1   sticky; see CONFIGURATION
// BEHAVIOUR
//  - Reset: all outputs 0; state HUNT; internal accumulators cleared; reset mid-frame requires full relock.
//  - Inputs registered once; hs_fall/vs_fall = registered low & previous high. Output latency 1 clk after input edge.
//  - Pixel timing: on hs_fall, h_count<=0 and phase<=0. Else phase++; at phase==CLKS_PER_PIXEL-1, phase wraps and h_count++.
//  - Line counter: on each hs_fall, v_count++; on vs_fall, v_count<=0 (wins over hs_fall in the same cycle).
//  - Sample point: phase==CLKS_PER_PIXEL/2. Pixel is visible iff hc in [H_VIS_START,H_VIS_END] and vc in [V_VIS_START,V_VIS_END].
//  - Checksum, per visible sample: acc <= {acc[14:0],acc[15]} ^ {4'h0,rgb_in}; pix_acc++ (19b).
//  - Line check: line_clk counts clocks since the last hs_fall. On hs_fall, if line_clk != H_TOTAL*CLKS_PER_PIXEL-1:
//    pulse line_err (except in HUNT), err_count++ saturating at 255, flag frame bad.
//  - States: HUNT -> ACQUIRE on vs_fall.
//    ACQUIRE, on vs_fall: lines==V_TOTAL and no line error -> LOCKED; else remain in ACQUIRE and restart counts.
//    LOCKED, on vs_fall: lines==V_TOTAL and pix_acc==640*480 -> frame_sum<=acc, pix_count<=pix_acc, pulse frame_done.
//    Otherwise pulse frame_err, go to HUNT, keep frame_sum/pix_count. A line_err alone does not drop lock.
//  - locked=1 only in LOCKED. acc, pix_acc and line count clear on every vs_fall.
//  - Probe: in LOCKED at the sample point with hc==probe_x and vc==probe_y, probe_rgb<=rgb_in. It holds otherwise.
//  - Widths: h_count/v_count hold at 1023 (no wrap) if sync is missing; pix_acc saturates at 2^19-1.
// CONFIGURATION
//  VGA_MON_BLANK_CHECK_EN defined: in LOCKED, any non-visible sample with rgb_in!=0 sets blank_err (sticky until reset).
//  Undefined: blank-check logic is absent and blank_err is tied 0.
// TESTING
//  1 reset held 3 clk mid-frame -> all outputs 0; locked=0 until 2 vs_falls of nominal timing.
//  2 nominal frames, all black except rgb 12'h00F at (783,514) -> locked after 2nd vs_fall; frame_sum=16'h000F, pix_count=307200.
//  3 all black except 12'h00F at (144,35) -> frame_sum=16'h8007; frame_done high for exactly 1 clk.
//  4 pattern rgb={hc[3:0],vc[3:0],4'hA}, probe=(200,100) -> probe_rgb=12'h84A.
//  5 line 300 shortened by 4 clk -> line_err pulse, err_count=1, locked stays 1.
//  6 frame of 524 lines -> frame_err pulse; locked=0 next clk; frame_sum unchanged.
//  7 blank-check on, rgb 12'h001 at hc=10 -> blank_err=1 sticky; with blank-check off, blank_err=0.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - VGA receive-side timing lock, per-frame checksum and error monitor
// Optional blank-region check enabled by defining VGA_MON_BLANK_CHECK_EN.
module vga_frame_monitor #(
  parameter int CLKS_PER_PIXEL = 4,
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int H_VIS_START    = 144,
  parameter int H_VIS_END      = 783,
  parameter int V_VIS_START    = 35,
  parameter int V_VIS_END      = 514
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        locked,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic [18:0] pix_count,
  output logic [11:0] probe_rgb,
  output logic        line_err,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        blank_err
);

  localparam int LINE_CLKS = H_TOTAL * CLKS_PER_PIXEL;
  localparam int VIS_PIX   = (H_VIS_END - H_VIS_START + 1) * (V_VIS_END - V_VIS_START + 1);
  localparam int PW        = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int LW        = $clog2(LINE_CLKS) + 1;

  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_PIXEL - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(CLKS_PER_PIXEL / 2);
  localparam logic [LW-1:0] LINE_LAST    = LW'(LINE_CLKS - 1);
  localparam logic [LW-1:0] LINE_MAX     = '1;
  localparam logic [9:0]    CNT_MAX      = 10'h3FF;
  localparam logic [18:0]   PIX_MAX      = 19'h7FFFF;

  typedef enum logic [1:0] {S_HUNT, S_ACQUIRE, S_LOCKED} state_t;

  state_t          state, state_nx;
  logic            hs_r, hs_prev, vs_r, vs_prev;
  logic [11:0]     rgb_r, rgb_d;
  logic [PW-1:0]   phase;
  logic [LW-1:0]   line_clk;
  logic [15:0]     acc;
  logic [18:0]     pix_acc;
  logic            frame_bad;
  logic            hs_fall, vs_fall, sample, visible;
  logic            line_bad, line_fault, lines_ok, pix_ok;
  logic            frame_ok, frame_fail;

  // rgb gets one extra stage so the phase-centred sample lines up with mid-pixel data
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r    <= 1'b0;
      hs_prev <= 1'b0;
      vs_r    <= 1'b0;
      vs_prev <= 1'b0;
      rgb_r   <= '0;
      rgb_d   <= '0;
    end else begin
      hs_r    <= hSync;
      hs_prev <= hs_r;
      vs_r    <= vSync;
      vs_prev <= vs_r;
      rgb_r   <= rgb_in;
      rgb_d   <= rgb_r;
    end
  end

  assign hs_fall  = hs_prev & ~hs_r;
  assign vs_fall  = vs_prev & ~vs_r;
  assign sample   = (phase == PHASE_SAMPLE);
  assign visible  = (h_count >= 10'(H_VIS_START)) && (h_count <= 10'(H_VIS_END)) &&
                    (v_count >= 10'(V_VIS_START)) && (v_count <= 10'(V_VIS_END));
  assign line_bad = hs_fall && (line_clk != LINE_LAST);
  assign lines_ok = (v_count == 10'(V_TOTAL - 1));
  assign pix_ok   = (pix_acc == 19'(VIS_PIX));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= '0;
      h_count  <= '0;
      v_count  <= '0;
      line_clk <= '0;
    end else begin
      if (hs_fall) begin
        h_count <= '0;
        phase   <= '0;
      end else if (phase == PHASE_LAST) begin
        phase <= '0;
        if (h_count != CNT_MAX) h_count <= h_count + 10'd1;
      end else begin
        phase <= phase + PW'(1);
      end

      if (vs_fall) v_count <= '0;
      else if (hs_fall && v_count != CNT_MAX) v_count <= v_count + 10'd1;

      if (hs_fall) line_clk <= '0;
      else if (line_clk != LINE_MAX) line_clk <= line_clk + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_HUNT:    if (vs_fall) state_nx = S_ACQUIRE;
      S_ACQUIRE: if (vs_fall && lines_ok && !(frame_bad || line_bad)) state_nx = S_LOCKED;
      S_LOCKED:  if (vs_fall && !(lines_ok && pix_ok)) state_nx = S_HUNT;
      default:   state_nx = S_HUNT;
    endcase
  end

  always_comb begin
    locked     = 1'b0;
    frame_ok   = 1'b0;
    frame_fail = 1'b0;
    line_fault = 1'b0;
    case (state)
      S_ACQUIRE: line_fault = line_bad;
      S_LOCKED: begin
        locked     = 1'b1;
        line_fault = line_bad;
        frame_ok   = vs_fall && lines_ok && pix_ok;
        frame_fail = vs_fall && !(lines_ok && pix_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      pix_acc    <= '0;
      frame_bad  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      err_count  <= '0;
      frame_sum  <= '0;
      pix_count  <= '0;
      probe_rgb  <= '0;
    end else begin
      frame_done <= frame_ok;
      frame_err  <= frame_fail;
      line_err   <= line_fault;
      if (line_fault && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (vs_fall) begin
        acc       <= '0;
        pix_acc   <= '0;
        frame_bad <= 1'b0;
      end else begin
        if (line_fault) frame_bad <= 1'b1;
        if (sample && visible) begin
          acc <= {acc[14:0], acc[15]} ^ {4'h0, rgb_d};
          if (pix_acc != PIX_MAX) pix_acc <= pix_acc + 19'd1;
        end
      end

      if (frame_ok) begin
        frame_sum <= acc;
        pix_count <= pix_acc;
      end

      if (locked && sample && h_count == probe_x && v_count == probe_y) probe_rgb <= rgb_d;
    end
  end

`ifdef VGA_MON_BLANK_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) blank_err <= 1'b0;
    else if (locked && sample && !visible && rgb_d != 12'h000) blank_err <= 1'b1;
  end
`else
  assign blank_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - bench for vga_frame_monitor on a reduced raster
// Frame-level reference model; honours VGA_MON_BLANK_CHECK_EN.
module tb_vga_frame_monitor;
  localparam int CPP = 4, HT = 24, VT = 14;
  localparam int HVS = 6, HVE = 21, VVS = 3, VVE = 12;
  localparam int HSW = 4, VSW = 2;
  localparam int VIS = (HVE - HVS + 1) * (VVE - VVS + 1);
  localparam int LAT = 2;
  localparam int M_HUNT = 0, M_ACQ = 1, M_LOCKED = 2;

  logic        clk = 1'b0, reset = 1'b1, hSync = 1'b1, vSync = 1'b1;
  logic [11:0] rgb_in = 12'h000;
  logic [9:0]  probe_x = 10'd10, probe_y = 10'd7;
  logic        locked, frame_done, line_err, frame_err, blank_err;
  logic [9:0]  h_count, v_count;
  logic [15:0] frame_sum;
  logic [18:0] pix_count;
  logic [11:0] probe_rgb;
  logic [7:0]  err_count;

  vga_frame_monitor #(
    .CLKS_PER_PIXEL(CPP), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_VIS_START(HVS), .H_VIS_END(HVE), .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .clk(clk), .reset(reset), .hSync(hSync), .vSync(vSync), .rgb_in(rgb_in),
    .probe_x(probe_x), .probe_y(probe_y), .locked(locked), .h_count(h_count),
    .v_count(v_count), .frame_done(frame_done), .frame_sum(frame_sum),
    .pix_count(pix_count), .probe_rgb(probe_rgb), .line_err(line_err),
    .frame_err(frame_err), .err_count(err_count), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [11:0] img [VT][HT];

  int          m_state = M_HUNT, m_pix = 0, m_err = 0;
  logic [15:0] m_sum = 16'h0;
  logic [11:0] m_probe = 12'h0;
  bit          m_blank = 1'b0;
  int          exp_done = 0, exp_fe = 0, exp_le = 0;
  int          p_lines = 0, p_pix = 0, frame_no = -1;
  bit          p_bad = 1'b0;
  logic [15:0] p_sum = 16'h0;

  // pulse cycle counters; a 1-cycle pulse adds exactly one per event
  int   n_done = 0, n_fe = 0, n_le = 0, n_lock_after_fe = 0;
  logic fe_q = 1'b0;
  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (frame_err)  n_fe++;
    if (line_err)   n_le++;
    if (fe_q && locked) n_lock_after_fe++;
    fe_q = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_h_count"}, h_count, 0);
    chk({tag, "_v_count"}, v_count, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_pix_count"}, pix_count, 0);
    chk({tag, "_probe_rgb"}, probe_rgb, 0);
    chk({tag, "_line_err"}, line_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_blank_err"}, blank_err, 0);
  endtask

  task automatic model_reset();
    m_state = M_HUNT; m_sum = 16'h0; m_pix = 0; m_probe = 12'h0; m_err = 0; m_blank = 1'b0;
  endtask

  // Frame-level outcome of the vsync that opened this frame, then compare the published state
  task automatic frame_start_checks();
    case (m_state)
      M_HUNT: m_state = M_ACQ;
      M_ACQ:  if (p_lines == VT && !p_bad) m_state = M_LOCKED;
      default: begin
        if (p_lines == VT && p_pix == VIS) begin
          m_sum = p_sum; m_pix = p_pix; exp_done++;
        end else begin
          exp_fe++; m_state = M_HUNT;
        end
      end
    endcase
    chk("locked", locked, m_state == M_LOCKED);
    chk("v_count_frame_start", v_count, 0);
    chk("frame_sum", frame_sum, m_sum);
    chk("pix_count", pix_count, m_pix);
    chk("err_count", err_count, m_err);
    chk("probe_rgb", probe_rgb, m_probe);
    chk("blank_err", blank_err, m_blank);
    chk("frame_done_cycles", n_done, exp_done);
    chk("frame_err_cycles", n_fe, exp_fe);
    chk("line_err_cycles", n_le, exp_le);
    if (frame_no == 2) chk("sum_last_visible_px", frame_sum, 16'h000F);
    if (frame_no == 3) chk("sum_first_visible_px", frame_sum, 16'h8007);
    if (frame_no == 4) chk("probe_pattern", probe_rgb, 12'hA7A);
    if (frame_no == 5) chk("err_count_after_short_line", err_count, 1);
  endtask

  task automatic fill(input int mode);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) begin
        bit vis;
        vis = h >= HVS && h <= HVE && v >= VVS && v <= VVE;
        case (mode)
          1:       img[v][h] = vis ? {h[3:0], v[3:0], 4'hA} : 12'h000;
          2:       img[v][h] = vis ? 12'($urandom) : 12'h000;
          default: img[v][h] = 12'h000;
        endcase
      end
  endtask

  task automatic run_frame(input int nlines, input int short_line, input int rst_line);
    logic [15:0] f_sum;
    int          f_pix;
    bit          f_bad;
    f_sum = 16'h0; f_pix = 0; f_bad = 1'b0;
    frame_no++;
    for (int ln = 0; ln < nlines; ln++) begin
      int len;
      len = (ln == short_line) ? HT * CPP - CPP : HT * CPP;
      for (int c = 0; c < len; c++) begin
        int hc;
        bit vis;
        hc  = c / CPP;
        vis = hc >= HVS && hc <= HVE && ln >= VVS && ln <= VVE;
        @(negedge clk);
        if (ln == 0 && c == 8) frame_start_checks();
        if (ln == 4 && c == 40) begin
          chk("h_count_mid_line", h_count, (40 - LAT) / CPP);
          chk("v_count_mid_frame", v_count, 4);
        end
        if (ln == rst_line && c == 0) reset = 1'b1;
        if (ln == rst_line && c == 3) begin
          check_reset_outputs("midframe_reset");
          reset = 1'b0;
          model_reset();
          f_sum = 16'h0; f_pix = 0; f_bad = 1'b0;
        end
        if (c % CPP == CPP / 2) begin
          if (m_state == M_LOCKED && ln == int'(probe_y) && hc == int'(probe_x)) m_probe = img[ln][hc];
`ifdef VGA_MON_BLANK_CHECK_EN
          if (m_state == M_LOCKED && !vis && img[ln][hc] != 12'h000) m_blank = 1'b1;
`endif
          if (vis) begin
            f_sum = {f_sum[14:0], f_sum[15]} ^ {4'h0, img[ln][hc]};
            f_pix++;
          end
        end
        hSync  = (hc >= HSW);
        vSync  = (ln >= VSW);
        rgb_in = img[ln][hc];
      end
      if (ln == short_line && ln < nlines - 1 && m_state != M_HUNT) begin
        exp_le++;
        if (m_err < 255) m_err++;
        f_bad = 1'b1;
      end
    end
    p_lines = nlines; p_bad = f_bad; p_pix = f_pix; p_sum = f_sum;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("power_on_reset");
    reset = 1'b0;
    model_reset();

    fill(0); run_frame(VT, -1, -1);
    fill(0); img[VVE][HVE] = 12'h00F; run_frame(VT, -1, -1);
    fill(0); img[VVS][HVS] = 12'h00F; run_frame(VT, -1, -1);
    fill(1); run_frame(VT, -1, -1);
    fill(2); run_frame(VT, 5, -1);
    fill(2); run_frame(VT - 1, -1, -1);
    fill(0); run_frame(VT, 5, -1);
    fill(2); run_frame(VT, 5, -1);
    fill(2); run_frame(VT, -1, -1);
    fill(2); img[5][2] = 12'h001; run_frame(VT, -1, -1);
    fill(2); run_frame(VT, -1, 6);
    for (int f = 0; f < 4; f++) begin
      fill(2); run_frame(VT, -1, -1);
    end
    fill(0); run_frame(1, -1, -1);

    hSync = 1'b1; vSync = 1'b1; rgb_in = 12'h000;
    repeat (1030 * CPP) @(negedge clk);
    chk("h_count_saturates", h_count, 10'h3FF);
    chk("locked_low_after_frame_err", n_lock_after_fe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
